// File: rtl/mag_comp_pkg.sv
// Shared types, ALU opcodes and the result saturator for the compensation datapath.
package mag_comp_pkg;

  typedef enum logic [3:0] {
    IDLE, OFF_SUB, OFF_MUL, OFF_ADD, SEN_SUB, SEN_MUL, SEN_ADD, COM_MUL, COM_SUB
  } state_t;

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] MUL = 2'd2;
  localparam logic [1:0] LOD = 2'd3;

  localparam int SAT_W = 64;
  localparam logic signed [SAT_W-1:0] SAT_ONE = SAT_W'(1);

  // Clip x into the signed dw-bit range; callers detect clipping by comparing to x.
  function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] x,
                                                       input int dw);
    logic signed [SAT_W-1:0] hi, lo;
    hi = (SAT_ONE <<< (dw - 1)) - SAT_ONE;
    lo = -hi - SAT_ONE;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/mag_comp_dsp_if.sv
// Sample-in / result-out handshake bundle.
interface mag_comp_dsp_if #(parameter int DW = 12, parameter int CHW = 2);
  logic                  in_valid, in_ready;
  logic signed [DW-1:0]  in_data;
  logic [CHW-1:0]        in_chan;
  logic                  out_valid, out_ready;
  logic signed [DW-1:0]  out_data;
  logic [CHW-1:0]        out_chan;
  logic                  out_sat;

  modport master (output in_valid, in_data, in_chan, out_ready,
                  input  in_ready, out_valid, out_data, out_chan, out_sat);
  modport slave  (input  in_valid, in_data, in_chan, out_ready,
                  output in_ready, out_valid, out_data, out_chan, out_sat);
endinterface

// File: rtl/mag_comp_alu.sv
// Combinational signed add/sub/mul/pass ALU, time-shared by the compensation sequencer.
module mag_comp_alu #(
  parameter int AW = 16,
  parameter int BW = 16,
  parameter int RW = 32
) (
  input  logic [1:0]           op,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [RW-1:0] y
);
  import mag_comp_pkg::*;

  logic signed [RW-1:0] ax, bx;
  assign ax = RW'(a);
  assign bx = RW'(b);

  always_comb begin
    case (op)
      ADD:     y = ax + bx;
      SUB:     y = ax - bx;
      MUL:     y = ax * bx;
      default: y = ax;
    endcase
  end
endmodule

// File: rtl/mag_comp_dsp.sv
// Per-channel averaging plus temperature-compensated gain/offset correction on one shared ALU.
module mag_comp_dsp #(
  parameter int DW       = 12,
  parameter int NCH      = 3,
  parameter int AVG_LOG2 = 2,
  parameter int CW       = 8,
  parameter int FRAC     = 6
) (
  input  logic                 prim_clk,
  input  logic                 prim_rst,
  input  logic                 enable,
  input  logic                 comp_en,
  input  logic                 temp_valid,
  input  logic signed [DW-1:0] temp_data,
  input  logic [NCH*CW-1:0]    off_tref,
  input  logic [NCH*CW-1:0]    off_oref,
  input  logic [NCH*CW-1:0]    off_gain,
  input  logic [NCH*CW-1:0]    sen_tref,
  input  logic [NCH*CW-1:0]    sen_oref,
  input  logic [NCH*CW-1:0]    sen_gain,
  mag_comp_dsp_if.slave        bus,
  output logic                 chan_err
);
  import mag_comp_pkg::*;

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACW = DW + AVG_LOG2;
  localparam int WW  = 2*DW + 2*CW + 4;
  localparam logic signed [WW-1:0] ONE = WW'(1) <<< FRAC;

  state_t                state;
  logic signed [ACW-1:0] acc [NCH];
  logic [AVG_LOG2-1:0]   cnt [NCH];
  logic signed [DW-1:0]  temp_r, t_snap, avg_r;
  logic [CHW-1:0]        chan_r;
  logic signed [WW-1:0]  tmp, off_r, sens_r;

  logic                  accept, chan_ok, last;
  logic signed [ACW-1:0] sum_c;
  logic signed [DW-1:0]  avg_c;

  assign bus.in_ready = enable && (state == IDLE) && !bus.out_valid;
  assign accept  = bus.in_valid && bus.in_ready;
  assign chan_ok = int'(bus.in_chan) < NCH;
  assign last    = chan_ok && (&cnt[bus.in_chan]);
  assign sum_c   = acc[bus.in_chan] + ACW'(bus.in_data);
  assign avg_c   = DW'(sum_c >>> AVG_LOG2);

  logic signed [CW-1:0] c_otref, c_ooref, c_ogain, c_stref, c_soref, c_sgain;
  assign c_otref = off_tref[chan_r*CW +: CW];
  assign c_ooref = off_oref[chan_r*CW +: CW];
  assign c_ogain = off_gain[chan_r*CW +: CW];
  assign c_stref = sen_tref[chan_r*CW +: CW];
  assign c_soref = sen_oref[chan_r*CW +: CW];
  assign c_sgain = sen_gain[chan_r*CW +: CW];

  logic [1:0]           op;
  logic signed [WW-1:0] opa, opb, alu_y;

  // One ALU operation per state; IDLE passes the fresh average through for bypass.
  always_comb begin
    op  = LOD;
    opa = WW'(avg_c);
    opb = '0;
    case (state)
      OFF_SUB: begin op = SUB; opa = WW'(t_snap);  opb = WW'(c_otref);       end
      OFF_MUL: begin op = MUL; opa = WW'(c_ogain); opb = tmp;                end
      OFF_ADD: begin op = ADD; opa = tmp;          opb = WW'(c_ooref);       end
      SEN_SUB: begin op = SUB; opa = WW'(t_snap);  opb = WW'(c_stref);       end
      SEN_MUL: begin op = MUL; opa = WW'(c_sgain); opb = tmp;                end
      SEN_ADD: begin op = ADD; opa = tmp;          opb = WW'(c_soref) + ONE; end
      COM_MUL: begin op = MUL; opa = WW'(avg_r);   opb = sens_r;             end
      COM_SUB: begin op = SUB; opa = tmp;          opb = off_r;              end
      default: ;
    endcase
  end

  mag_comp_alu #(.AW(WW), .BW(WW), .RW(WW)) u_alu (
    .op(op), .a(opa), .b(opb), .y(alu_y)
  );

  logic signed [SAT_W-1:0] res_ext, sat_val;
  logic                    sat_hit;
  assign res_ext = SAT_W'(alu_y);
  assign sat_val = sat_clip(res_ext, DW);
  assign sat_hit = (sat_val != res_ext);

  always_ff @(posedge prim_clk) begin
    if (prim_rst) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      bus.out_sat   <= 1'b0;
      chan_err      <= 1'b0;
      temp_r        <= '0;
      t_snap        <= '0;
      avg_r         <= '0;
      chan_r        <= '0;
      tmp           <= '0;
      off_r         <= '0;
      sens_r        <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      chan_err <= accept && !chan_ok;
      if (temp_valid) temp_r <= temp_data;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        IDLE: if (accept && chan_ok) begin
          if (last) begin
            acc[bus.in_chan] <= '0;
            cnt[bus.in_chan] <= '0;
            t_snap <= temp_r;
            avg_r  <= avg_c;
            chan_r <= bus.in_chan;
            if (comp_en) state <= OFF_SUB;
            else begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= DW'(alu_y);
              bus.out_chan  <= bus.in_chan;
              bus.out_sat   <= 1'b0;
            end
          end else begin
            acc[bus.in_chan] <= sum_c;
            cnt[bus.in_chan] <= cnt[bus.in_chan] + AVG_LOG2'(1);
          end
        end
        OFF_SUB: begin tmp    <= alu_y;          state <= OFF_MUL; end
        OFF_MUL: begin tmp    <= alu_y >>> FRAC; state <= OFF_ADD; end
        OFF_ADD: begin off_r  <= alu_y;          state <= SEN_SUB; end
        SEN_SUB: begin tmp    <= alu_y;          state <= SEN_MUL; end
        SEN_MUL: begin tmp    <= alu_y >>> FRAC; state <= SEN_ADD; end
        SEN_ADD: begin sens_r <= alu_y;          state <= COM_MUL; end
        COM_MUL: begin tmp    <= alu_y >>> FRAC; state <= COM_SUB; end
        COM_SUB: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= DW'(sat_val);
          bus.out_chan  <= chan_r;
          bus.out_sat   <= sat_hit;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mag_comp_dsp.sv
// Directed-vector bench for mag_comp_dsp: bypass, compensation, saturation, ordering, reset.
module tb_mag_comp_dsp;
  localparam int DW = 12, NCH = 3, AVG_LOG2 = 2, CW = 8, FRAC = 6, CHW = 2;

  logic prim_clk = 1'b0;
  logic prim_rst, enable, comp_en, temp_valid, chan_err;
  logic signed [DW-1:0] temp_data;
  logic [NCH*CW-1:0] off_tref, off_oref, off_gain, sen_tref, sen_oref, sen_gain;
  int checks = 0, failures = 0;

  always #5 prim_clk = ~prim_clk;

  mag_comp_dsp_if #(.DW(DW), .CHW(CHW)) bus ();

  mag_comp_dsp #(.DW(DW), .NCH(NCH), .AVG_LOG2(AVG_LOG2), .CW(CW), .FRAC(FRAC)) dut (
    .prim_clk(prim_clk), .prim_rst(prim_rst), .enable(enable), .comp_en(comp_en),
    .temp_valid(temp_valid), .temp_data(temp_data),
    .off_tref(off_tref), .off_oref(off_oref), .off_gain(off_gain),
    .sen_tref(sen_tref), .sen_oref(sen_oref), .sen_gain(sen_gain),
    .bus(bus), .chan_err(chan_err)
  );

  task automatic tick();
    @(posedge prim_clk); #1;
  endtask

  task automatic set_coef(input int ch, input int otref, input int ooref, input int ogain,
                          input int stref, input int soref, input int sgain);
    off_tref[ch*CW +: CW] = CW'(otref);
    off_oref[ch*CW +: CW] = CW'(ooref);
    off_gain[ch*CW +: CW] = CW'(ogain);
    sen_tref[ch*CW +: CW] = CW'(stref);
    sen_oref[ch*CW +: CW] = CW'(soref);
    sen_gain[ch*CW +: CW] = CW'(sgain);
  endtask

  task automatic set_temp(input int t);
    temp_valid = 1'b1; temp_data = DW'(t);
    tick();
    temp_valid = 1'b0;
  endtask

  // Returns one cycle after the accepting edge.
  task automatic send(input int ch, input int d);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_chan = CHW'(ch); bus.in_data = DW'(d);
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout ch=%0d in_ready never rose", ch);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic feed(input int ch, input int d, input int n);
    repeat (n) send(ch, d);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    if (!bus.out_valid) begin
      checks++; failures++;
      $display("FAIL %s_timeout out_valid stayed 0", name);
    end
  endtask

  task automatic test_reset();
    prim_rst = 1'b1;
    tick(); tick();
    prim_rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== DW'(0)) begin failures++; $display("FAIL rst_out_data got=%0d exp=0", bus.out_data); end
    checks++; if (bus.out_chan !== CHW'(0)) begin failures++; $display("FAIL rst_out_chan got=%0d exp=0", bus.out_chan); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL rst_out_sat got=%b exp=0", bus.out_sat); end
    checks++; if (chan_err !== 1'b0) begin failures++; $display("FAIL rst_chan_err got=%b exp=0", chan_err); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_bypass();
    comp_en = 1'b0;
    send(0, 100); send(0, 102); send(0, 98);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL byp_early got=%b exp=0", bus.out_valid); end
    send(0, 104);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL byp_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== DW'(101)) begin failures++; $display("FAIL byp_data got=%0d exp=101", bus.out_data); end
    checks++; if (bus.out_chan !== CHW'(0)) begin failures++; $display("FAIL byp_chan got=%0d exp=0", bus.out_chan); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL byp_in_ready got=%b exp=0", bus.in_ready); end
    tick(); tick(); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(101)) begin
      failures++; $display("FAIL byp_hold got=%b/%0d exp=1/101", bus.out_valid, bus.out_data);
    end
    take();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL byp_drop got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL byp_ready_back got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_comp_basic();
    bit early = 1'b0;
    comp_en = 1'b1;
    set_coef(0, 25, 10, 0, 25, 0, 0);
    set_temp(25);
    feed(0, 200, 3);
    send(0, 200);
    repeat (7) begin tick(); if (bus.out_valid) early = 1'b1; end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL comp_early got=%b exp=0", early); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL comp_latency got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== DW'(190)) begin failures++; $display("FAIL comp_data got=%0d exp=190", bus.out_data); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL comp_sat got=%b exp=0", bus.out_sat); end
    take();
  endtask

  // Temperature reload and enable drop mid-sequence must not disturb the running result.
  task automatic test_comp_temp();
    comp_en = 1'b1;
    set_coef(0, 25, 0, 32, 25, 0, 64);
    set_temp(35);
    feed(0, 64, 4);
    enable = 1'b0;
    set_temp(100);
    wait_valid("temp");
    checks++; if (bus.out_data !== DW'(69)) begin failures++; $display("FAIL temp_data got=%0d exp=69", bus.out_data); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL temp_sat got=%b exp=0", bus.out_sat); end
    enable = 1'b1;
    take();
  endtask

  task automatic test_saturation();
    comp_en = 1'b1;
    set_coef(0, 0, 0, 0, 0, 64, 0);
    feed(0, 2000, 4);
    wait_valid("sat_pos");
    checks++; if (bus.out_data !== DW'(2047)) begin failures++; $display("FAIL sat_pos_data got=%0d exp=2047", bus.out_data); end
    checks++; if (bus.out_sat !== 1'b1) begin failures++; $display("FAIL sat_pos_flag got=%b exp=1", bus.out_sat); end
    take();
    feed(0, -2000, 4);
    wait_valid("sat_neg");
    checks++; if (bus.out_data !== DW'(-2048)) begin failures++; $display("FAIL sat_neg_data got=%0d exp=-2048", bus.out_data); end
    checks++; if (bus.out_sat !== 1'b1) begin failures++; $display("FAIL sat_neg_flag got=%b exp=1", bus.out_sat); end
    take();
  endtask

  task automatic test_round_robin();
    bit rdy_seen = 1'b0, stable = 1'b1;
    comp_en = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) send(c, (c + 1) * 10);
    send(0, 10);
    checks++; if (bus.out_data !== DW'(10) || bus.out_chan !== CHW'(0)) begin
      failures++; $display("FAIL rr_ch0 got=%0d/ch%0d exp=10/ch0", bus.out_data, bus.out_chan);
    end
    repeat (20) begin
      tick();
      if (bus.in_ready) rdy_seen = 1'b1;
      if (!bus.out_valid || bus.out_data !== DW'(10)) stable = 1'b0;
    end
    checks++; if (rdy_seen !== 1'b0) begin failures++; $display("FAIL rr_backpressure in_ready got=1 exp=0"); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL rr_hold got=%b exp=1", stable); end
    take();
    send(3, 500);
    checks++; if (chan_err !== 1'b1) begin failures++; $display("FAIL rr_chan_err got=%b exp=1", chan_err); end
    tick();
    checks++; if (chan_err !== 1'b0) begin failures++; $display("FAIL rr_chan_err_pulse got=%b exp=0", chan_err); end
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL rr_bad_chan_state got=%b/%b exp=0/1", bus.out_valid, bus.in_ready);
    end
    send(1, 20);
    checks++; if (bus.out_data !== DW'(20) || bus.out_chan !== CHW'(1)) begin
      failures++; $display("FAIL rr_ch1 got=%0d/ch%0d exp=20/ch1", bus.out_data, bus.out_chan);
    end
    take();
    send(2, 30);
    checks++; if (bus.out_data !== DW'(30) || bus.out_chan !== CHW'(2)) begin
      failures++; $display("FAIL rr_ch2 got=%0d/ch%0d exp=30/ch2", bus.out_data, bus.out_chan);
    end
    take();
  endtask

  task automatic test_reset_mid();
    bit leaked = 1'b0;
    comp_en = 1'b1;
    set_coef(0, 0, 0, 0, 0, 0, 0);
    send(1, 99); send(1, 99);
    feed(0, 77, 4);
    repeat (4) tick();
    prim_rst = 1'b1; bus.out_ready = 1'b1;
    tick();
    prim_rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", bus.in_ready); end
    repeat (10) begin tick(); if (bus.out_valid) leaked = 1'b1; end
    checks++; if (leaked !== 1'b0) begin failures++; $display("FAIL rmid_leak got=%b exp=0", leaked); end
    comp_en = 1'b0;
    feed(1, 50, 4);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(50)) begin
      failures++; $display("FAIL rmid_fresh got=%b/%0d exp=1/50", bus.out_valid, bus.out_data);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    prim_rst = 1'b1; enable = 1'b1; comp_en = 1'b0; temp_valid = 1'b0; temp_data = '0;
    off_tref = '0; off_oref = '0; off_gain = '0; sen_tref = '0; sen_oref = '0; sen_gain = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_chan = '0; bus.out_ready = 1'b0;
    test_reset();
    test_bypass();
    test_comp_basic();
    test_comp_temp();
    test_saturation();
    test_round_robin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mag_comp_dsp.md
# mag_comp_dsp

Parametrised temperature-compensated measurement datapath for NCH multiplexed ADC channels. It averages 2^AVG_LOG2 signed samples per channel and derives a temperature-dependent offset and sensitivity from per-channel coefficients. It computes `sens*avg - offset` on one shared multiplier/adder sequencer and returns a saturated result over a valid/ready handshake. It sits between the measurement sequencer/ADC front end and the result register bank.

## Interface
- DW, 12, sample, temperature and result width (signed)
- NCH, 3, channel count
- AVG_LOG2, 2, log2 of samples averaged per result
- CW, 8, coefficient width (signed)
- FRAC, 6, fractional bits of gain/sensitivity (Q.FRAC)
- CHW, $clog2(NCH) (min 1), channel index width (derived localparam)

Ports:
- prim_clk  in  1  clock
- prim_rst  in  1  reset, synchronous, active-high
- enable  in  1  accept new samples when high
- comp_en  in  1  1: compensated result, 0: bypass (plain average)
- temp_valid  in  1  load temp_data
- temp_data  in  DW  signed temperature code
- off_tref, off_oref, off_gain  in  NCH*CW  per-channel offset coefficients, channel i at [i*CW +: CW]
- sen_tref, sen_oref, sen_gain  in  NCH*CW  per-channel sensitivity coefficients, same packing
- in_valid / in_ready  in / out  1  sample handshake
- in_data  in  DW  signed sample
- in_chan  in  CHW  sample channel
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  DW  signed result
- out_chan  out  CHW  result channel
- out_sat  out  1  result was clipped
- chan_err  out  1  one-cycle pulse: accepted sample had in_chan >= NCH

## Operation
- Per channel: accumulator (DW+AVG_LOG2 signed) and sample counter (AVG_LOG2 bits).
- A sample is accepted when in_valid && in_ready. It is added to acc[in_chan] and cnt[in_chan] increments.
- When the accepted sample is the 2^AVG_LOG2-th:
  - sum = acc + in_data goes to a working register;
  - acc and cnt for that channel are cleared;
  - temp register is snapshotted;
  - avg = sum >>> AVG_LOG2 (arithmetic).
- in_chan >= NCH: sample accepted, discarded, chan_err pulses.
- Temp register loads on temp_valid at any time. A running sequence uses only the snapshot.
- Compensation, all signed, products full width, >>> arithmetic:
  - off = ((off_gain*(T - off_tref)) >>> FRAC) + off_oref
  - sens = (1<<FRAC) + ((sen_gain*(T - sen_tref)) >>> FRAC) + sen_oref
  - res = ((avg*sens) >>> FRAC) - off
  - res is clipped to [-2^(DW-1), 2^(DW-1)-1]; out_sat = 1 if clipped.
- Bypass (comp_en=0): res = avg, out_sat=0.
- comp_en is sampled at the completing accept.
- FSM states: IDLE, OFF_SUB, OFF_MUL, OFF_ADD, SEN_SUB, SEN_MUL, SEN_ADD, COM_MUL, COM_SUB.
  - IDLE→OFF_SUB on a completing accept with comp_en=1; then the states advance one per cycle.
  - COM_SUB loads the output register and returns to IDLE.
  - Bypass loads the output register directly from IDLE.
- in_ready = enable && state==IDLE && !out_valid. Only one result is in flight, so nothing is lost or overwritten.
- enable deasserted mid-sequence: the sequence completes; accumulators are retained.

## Timing
- Completing accept at cycle 0:
  - bypass: out_valid high from cycle 1;
  - compensated: out_valid high from cycle 9.
- out_valid, out_data, out_chan and out_sat hold stable until out_valid && out_ready. out_valid drops the next cycle.
- in_ready is combinational from registered state plus enable.
- chan_err is registered and high in cycle 1.
- Reset (any cycle, including mid-sequence), next cycle:
  - state=IDLE;
  - out_valid=0, out_data=0, out_chan=0, out_sat=0, chan_err=0;
  - all acc/cnt=0, temp=0.

## Structure
- Shared package mag_comp_pkg holds:
  - the state enum;
  - the ALU opcode constants (ADD, SUB, MUL, LOD);
  - a saturate function.
- One sub-module: mag_comp_alu, a combinational signed add/sub/mul/pass-through with parametrised operand widths, instantiated once and time-shared by the FSM.

## Test plan
Defaults, T in LSB.
- Bypass, comp_en=0: ch0 samples 100, 102, 98, 104 → out_data=101, out_chan=0, out_valid at cycle 1 after 4th accept.
- Compensated, T=25, tref=25, gains 0, off_oref=10, sen_oref=0: four samples of 200 → out_data=190, out_sat=0, out_valid at cycle 9.
- T=35, off_tref=25, off_gain=32, sen_tref=25, sen_gain=64, orefs 0: samples 64 → off=5, sens=74, out_data=69.
- Saturation, sen_oref=64, gains 0, oref_o 0:
  - samples 2000 → 2047, out_sat=1;
  - samples -2000 → -2048, out_sat=1.
- Round-robin ch0/1/2, 4 samples each (10/20/30), with out_ready low 20 cycles after first result:
  - in_ready stays low;
  - results emitted in order ch0=10, ch1=20, ch2=30;
  - in_chan=3 → chan_err pulse, no state change.
- prim_rst asserted in SEN_MUL, then out_ready high:
  - next cycle out_valid=0, in_ready=1;
  - 4 new samples of 50 in bypass → out_data=50 (no stale accumulation).
